mac_acc_stage: RTL and testbench
================================

MAC_ACC_STAGE -- requirements
Module: mac_acc_stage

Interface
REQ-001 SHALL have parameter DIGITS, default 128, the radix-4 digit count; the incoming product width is DIGITS*4.
REQ-002 SHALL have parameter ACC_W, default 576, the accumulator width; ACC_W >= DIGITS*4 and ACC_W is a multiple of CHUNK.
REQ-003 SHALL have parameter CHUNK, default 64, the adder slice width per cycle; NCHUNK = ACC_W/CHUNK.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 prod  input  DIGITS*4  unsigned product from the multiplier stage.
REQ-007 prod_valid  input  1  prod is valid this cycle.
REQ-008 prod_ready  output  1  stage can accept prod this cycle.
REQ-009 clear  input  1  synchronous accumulator clear request.
REQ-010 acc_out  output  ACC_W  accumulator register, driven directly.
REQ-011 acc_valid  output  1  one-cycle pulse: acc_out holds a completed sum.
REQ-012 ovf  output  1  sticky overflow flag.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-014 prod_ready SHALL be 1 in IDLE only.
REQ-015 In IDLE, when prod_valid&prod_ready is high, the stage SHALL capture prod zero-extended to ACC_W, set the chunk index to 0 and the carry to 0, and enter ADD.
REQ-016 Each ADD cycle SHALL update acc slice[idx] to acc slice[idx] + op slice[idx] + carry, latch the slice carry-out, and increment idx.
REQ-017 When idx = NCHUNK-1, the ADD cycle SHALL move the FSM to DONE, and its carry-out SHALL OR into ovf.
REQ-018 DONE SHALL assert acc_valid for exactly one cycle, then return to IDLE.
REQ-019 Latency: for a handshake in cycle T, acc_valid SHALL be high in cycle T+NCHUNK+1; minimum accept interval SHALL be NCHUNK+2 cycles.
REQ-020 Accumulation SHALL wrap modulo 2^ACC_W.
REQ-021 clear in IDLE without a handshake SHALL zero acc_out and ovf on the next edge; acc_valid SHALL stay 0.
REQ-022 clear together with a handshake in IDLE SHALL zero the accumulator and ovf, then accumulate the captured product, giving a result equal to prod.
REQ-023 clear asserted in ADD or DONE SHALL be ignored.
REQ-024 prod and prod_valid SHALL be ignored while prod_ready=0.
REQ-025 acc_out SHALL change only in ADD, on clear, or on reset.

Reset
REQ-026 On rst_n low, at any time including mid-ADD, the stage SHALL enter IDLE with acc_out=0, ovf=0, acc_valid=0, prod_ready=1, idx=0, carry=0 and the operand register cleared; any in-flight product SHALL be discarded.

Configuration
REQ-027 With MAC_ACC_OVF_EN defined, ovf SHALL behave per REQ-017 and REQ-021/022.
REQ-028 Without MAC_ACC_OVF_EN, ovf SHALL be tied to 0, no overflow register SHALL exist, and the final carry SHALL be dropped.

Structure
REQ-029 A shared package mac_pkg SHALL hold the FSM state encodings (IDLE, ADD, DONE) and the default constants for DIGITS, ACC_W and CHUNK.
REQ-030 The design SHALL instantiate exactly one sub-module, acc_chunk_add, a CHUNK-bit adder with cin and cout used for the per-cycle slice add.

Verification (DIGITS=128, CHUNK=64, ACC_W=576 unless stated)
REQ-031 Reset then idle -> acc_out=0, prod_ready=1, acc_valid=0, ovf=0.
REQ-032 Accept prod=0xFFFF_FFFF_FFFF_FFFF, then accept prod=1 -> second result acc_out=2^64 (carry crosses slice 0->1); each acc_valid pulse occurs exactly 10 cycles after its handshake.
REQ-033 prod_valid held high with prod=3 then 5 -> prod_ready low for 10 cycles between accepts; final acc_out=8.
REQ-034 With acc_out=8, assert clear with a prod=7 handshake -> acc_out=7 and ovf=0; separately, assert clear during ADD -> no effect on the sum.
REQ-035 With ACC_W=512 and MAC_ACC_OVF_EN defined, accept 2^512-1 then 1 -> acc_out=0 and ovf=1, with ovf held until clear; the same test without the macro -> acc_out=0 and ovf=0.
REQ-036 Drop rst_n low in the 4th ADD cycle after accepting prod=0x1234 -> acc_out=0, IDLE, prod_ready=1, and no acc_valid pulse.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared FSM encoding and default sizing for the MAC accumulate stage.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAC_DIGITS = 128;
  localparam int unsigned MAC_ACC_W  = 576;
  localparam int unsigned MAC_CHUNK  = 64;

  // Index width that stays legal even for a single-chunk accumulator.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_chunk_add.sv
// One accumulator slice adder: sum = a + b + cin, with carry-out.
module acc_chunk_add
  import mac_pkg::*;
#(
  parameter int unsigned W = MAC_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);

endmodule

// File: rtl/mac_acc_stage.sv
// Multi-cycle accumulate stage: adds a captured product into the accumulator
// one CHUNK slice per cycle. Define MAC_ACC_OVF_EN to keep a sticky overflow flag.
module mac_acc_stage
  import mac_pkg::*;
#(
  parameter int unsigned DIGITS = MAC_DIGITS,
  parameter int unsigned ACC_W  = MAC_ACC_W,
  parameter int unsigned CHUNK  = MAC_CHUNK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS*4-1:0]   prod,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic                  clear,
  output logic [ACC_W-1:0]      acc_out,
  output logic                  acc_valid,
  output logic                  ovf
);

  localparam int unsigned NCHUNK = ACC_W / CHUNK;
  localparam int unsigned IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  op;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [31:0]       base;
  logic [CHUNK-1:0]  acc_slice;
  logic [CHUNK-1:0]  op_slice;
  logic [CHUNK-1:0]  sum_slice;
  logic              cout;
  logic              accept;
  logic              last;

  assign accept    = prod_valid & prod_ready;
  assign last      = (idx == LAST_IDX);
  assign base      = 32'(idx) * CHUNK;
  assign acc_slice = acc[base +: CHUNK];
  assign op_slice  = op[base +: CHUNK];
  assign acc_out   = acc;

  acc_chunk_add #(
    .W (CHUNK)
  ) u_add (
    .a    (acc_slice),
    .b    (op_slice),
    .cin  (carry),
    .sum  (sum_slice),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod_ready = (state == IDLE);
    acc_valid  = (state == DONE);
  end

  // Clear and capture share the IDLE edge: the sum restarts from zero and
  // the freshly captured operand is added during the following ADD cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      op    <= '0;
      idx   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) acc <= '0;
          if (accept) begin
            op    <= ACC_W'(prod);
            idx   <= '0;
            carry <= 1'b0;
          end
        end
        ADD: begin
          acc[base +: CHUNK] <= sum_slice;
          carry              <= cout;
          idx                <= last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MAC_ACC_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && clear) begin
      ovf_q <= 1'b0;
    end else if (state == ADD && last && cout) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_acc_stage.sv
// Self-checking bench for mac_acc_stage: vector table + scoreboard, plus
// directed clear / overflow / mid-ADD reset sequences.
module tb_mac_acc_stage;

  localparam int unsigned LAT = 10;
`ifdef MAC_ACC_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] prod;
  logic         prod_valid;
  logic         prod_ready;
  logic         clear;
  logic [575:0] acc_out;
  logic         acc_valid;
  logic         ovf;

  logic [511:0] prod2;
  logic         prod_valid2;
  logic         prod_ready2;
  logic         clear2;
  logic [511:0] acc_out2;
  logic         acc_valid2;
  logic         ovf2;

  always #5 clk = ~clk;

  mac_acc_stage #(.DIGITS(128), .ACC_W(576), .CHUNK(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .clear      (clear),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .ovf        (ovf)
  );

  mac_acc_stage #(.DIGITS(128), .ACC_W(512), .CHUNK(64)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod       (prod2),
    .prod_valid (prod_valid2),
    .prod_ready (prod_ready2),
    .clear      (clear2),
    .acc_out    (acc_out2),
    .acc_valid  (acc_valid2),
    .ovf        (ovf2)
  );

  typedef struct {
    logic         clr;
    logic [511:0] p;
    logic [575:0] exp;
  } vec_t;

  typedef struct {
    logic [575:0] acc;
    logic         ovf;
    int unsigned  hs;
  } sb_t;

  sb_t         sb[$];
  vec_t        tab[8];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [575:0] got, input logic [575:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [511:0] p, input logic c, input logic [575:0] e, input logic eo);
    int unsigned w = 0;
    sb_t ent;
    @(negedge clk);
    prod = p;
    prod_valid = 1'b1;
    clear = c;
    while (!prod_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", prod_ready, 1);
    if (!prod_ready) return;
    @(posedge clk);
    ent.acc = e;
    ent.ovf = eo;
    ent.hs  = cyc;
    sb.push_back(ent);
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  task automatic send2(input logic [511:0] p);
    int unsigned w = 0;
    @(negedge clk);
    prod2 = p;
    prod_valid2 = 1'b1;
    while (!prod_ready2 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready2_wait", prod_ready2, 1);
    @(posedge clk);
    @(negedge clk);
    prod_valid2 = 1'b0;
    w = 0;
    while (!acc_valid2 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("valid2_seen", acc_valid2, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst_n = 1'b0;
    prod = '0; prod_valid = 1'b0; clear = 1'b0;
    prod2 = '0; prod_valid2 = 1'b0; clear2 = 1'b0;

    fork
      begin : monitor
        int unsigned run = 0;
        sb_t e;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            run = 0;
          end else begin
            if (acc_valid) begin
              n_valid++;
              if (sb.size() == 0) begin
                chk("unexpected_valid", acc_valid, 0);
              end else begin
                e = sb.pop_front();
                chk("acc_out", acc_out, e.acc);
                chk("ovf", ovf, e.ovf);
                chk("latency", cyc - e.hs, LAT);
              end
            end
            if (!prod_ready) begin
              run++;
            end else begin
              if (run != 0) chk("ready_low_cycles", run, LAT);
              run = 0;
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc", acc_out, 0);
    chk("rst_ready", prod_ready, 1);
    chk("rst_valid", acc_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_acc2", acc_out2, 0);

    tab[0] = '{1'b0, 512'hFFFF_FFFF_FFFF_FFFF, 576'hFFFF_FFFF_FFFF_FFFF};
    tab[1] = '{1'b0, 512'd1, 576'd1 << 64};
    tab[2] = '{1'b1, 512'd3, 576'd3};
    tab[3] = '{1'b0, 512'd5, 576'd8};
    tab[4] = '{1'b1, 512'd7, 576'd7};
    tab[5] = '{1'b0, {512{1'b1}}, (576'd1 << 512) + 576'd6};
    tab[6] = '{1'b0, {512{1'b1}}, (576'd1 << 513) + 576'd5};
    tab[7] = '{1'b1, 512'd1 << 511, 576'd1 << 511};

    for (int i = 0; i < 8; i++) begin
      send(tab[i].p, tab[i].clr, tab[i].exp, 1'b0);
    end
    @(negedge clk);
    prod_valid = 1'b0;
    clear = 1'b0;
    drain();

    // clear while ADD is in progress must not disturb the sum
    send(512'd2, 1'b0, (576'd1 << 511) + 576'd2, 1'b0);
    @(negedge clk);
    prod_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    drain();

    // clear alone in IDLE
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_only_acc", acc_out, 0);
    chk("clear_only_ovf", ovf, 0);
    chk("clear_only_valid", acc_valid, 0);
    chk("clear_only_ready", prod_ready, 1);

    send(512'd9, 1'b0, 576'd9, 1'b0);
    @(negedge clk);
    prod_valid = 1'b0;
    drain();

    // 512-bit accumulator wrap and sticky overflow
    send2({512{1'b1}});
    chk("acc2_ones", acc_out2, {64'd0, {512{1'b1}}});
    chk("ovf2_before", ovf2, 0);
    send2(512'd1);
    chk("acc2_wrap", acc_out2, 0);
    chk("ovf2_wrap", ovf2, EXP_OVF);
    repeat (5) @(negedge clk);
    chk("ovf2_sticky", ovf2, EXP_OVF);
    clear2 = 1'b1;
    @(negedge clk);
    clear2 = 1'b0;
    chk("ovf2_cleared", ovf2, 0);
    chk("acc2_cleared", acc_out2, 0);

    // reset during the fourth ADD cycle discards the product
    send(512'h1234, 1'b0, 576'h1234, 1'b0);
    @(negedge clk);
    prod_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    nv = n_valid;
    #1;
    chk("midadd_rst_acc", acc_out, 0);
    chk("midadd_rst_ready", prod_ready, 1);
    chk("midadd_rst_valid", acc_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midadd_no_pulse", n_valid, nv);
    chk("midadd_acc_after", acc_out, 0);
    chk("midadd_ready_after", prod_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
